// File: rtl/uniq_pkg.sv
// Shared types and defaults for the unique-value decoder frame sequencer.
// Holds the sequencer state encoding and the default decoder geometry.
package uniq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STREAM  = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } uniq_state_e;

    localparam int UNIQ_NUM_SLOTS = 4;
    localparam int UNIQ_DATA_W    = 8;

endpackage

// File: rtl/uniq_slot_picker.sv
// Priority encoder over the remaining-valid slot mask, lowest index first; purely combinational.
// Also flags when the picked slot is the highest remaining one (final beat of the frame).
module uniq_slot_picker
    import uniq_pkg::*;
#(
    parameter int NUM_SLOTS = UNIQ_NUM_SLOTS
) (
    input  logic [NUM_SLOTS-1:0]         mask_in,
    output logic [$clog2(NUM_SLOTS)-1:0] idx_out,
    output logic                         any_out,
    output logic                         last_out
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    always_comb begin
        idx_out = '0;
        any_out = |mask_in;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (mask_in[k]) begin
                idx_out = IDX_W'(k);
            end
        end
        // Last when nothing else remains once the picked slot is removed.
        last_out = any_out && ((mask_in & ~(NUM_SLOTS'(1) << idx_out)) == '0);
    end

endmodule

// File: rtl/uniq_frame_ctrl.sv
// Frames the free-running unique-value decoder: streams one frame in, settles, captures slots, drains valid slots.
// Output appears FLUSH_CYC+1 cycles after the last input beat; input stalls outside IDLE/STREAM, output holds until m_ready_in.
module uniq_frame_ctrl
    import uniq_pkg::*;
#(
    parameter int DATA_W    = UNIQ_DATA_W,
    parameter int NUM_SLOTS = UNIQ_NUM_SLOTS,
    parameter int MAX_LEN   = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic [DATA_W-1:0]             s_data_in,
    input  logic                          s_valid_in,
    input  logic                          s_last_in,
    output logic                          s_ready_out,
    output logic                          dec_reset_out,
    output logic [DATA_W-1:0]             dec_data_out,
    input  logic [NUM_SLOTS*DATA_W-1:0]   dec_out_in,
    input  logic [NUM_SLOTS-1:0]          dec_valid_in,
    output logic [DATA_W-1:0]             m_data_out,
    output logic [$clog2(NUM_SLOTS)-1:0]  m_slot_out,
    output logic                          m_valid_out,
    output logic                          m_last_out,
    output logic                          m_err_out,
    input  logic                          m_ready_in,
    output logic                          empty_out
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FC_W   = $clog2(FLUSH_CYC + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V  = LEN_W'(MAX_LEN);
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYC - 1);

    uniq_state_e                 state_q, state_d;
    logic [DATA_W-1:0]           dec_data_q, dec_data_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic                        err_q, err_d;
    logic [FC_W-1:0]             flush_cnt_q, flush_cnt_d;
    logic [NUM_SLOTS*DATA_W-1:0] slot_dat_q, slot_dat_d;
    logic [NUM_SLOTS-1:0]        mask_q, mask_d;
    logic                        empty_q, empty_d;

    logic [SLOT_W-1:0] pick_idx;
    logic              pick_any;
    logic              pick_last;
    logic              drain_vld;
    logic              s_hs;
    logic              m_hs;

    uniq_slot_picker #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_picker (
        .mask_in  (mask_q),
        .idx_out  (pick_idx),
        .any_out  (pick_any),
        .last_out (pick_last)
    );

    assign drain_vld = (state_q == ST_DRAIN) && pick_any;
    assign s_hs      = s_valid_in && s_ready_out;
    assign m_hs      = drain_vld && m_ready_in;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (s_hs) state_d = s_last_in ? ST_FLUSH : ST_STREAM;
            ST_STREAM:  if (s_hs && s_last_in) state_d = ST_FLUSH;
            ST_FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = (|dec_valid_in) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:   if (m_hs && pick_last) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Beats beyond MAX_LEN are still accepted so the frame boundary is found, but never reach the decoder.
    always_comb begin
        dec_data_d  = dec_data_q;
        len_d       = len_q;
        err_d       = err_q;
        flush_cnt_d = '0;
        slot_dat_d  = slot_dat_q;
        mask_d      = mask_q;
        empty_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_hs) begin
                    dec_data_d = s_data_in;
                    len_d      = LEN_W'(1);
                    err_d      = 1'b0;
                end
            end
            ST_STREAM: begin
                if (s_hs) begin
                    if (len_q < MAX_LEN_V) begin
                        dec_data_d = s_data_in;
                        len_d      = len_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: flush_cnt_d = flush_cnt_q + 1'b1;
            ST_CAPTURE: begin
                slot_dat_d = dec_out_in;
                mask_d     = dec_valid_in;
                empty_d    = ~|dec_valid_in;
            end
            ST_DRAIN: begin
                if (m_hs) begin
                    mask_d = mask_q & ~(NUM_SLOTS'(1) << pick_idx);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            dec_data_q  <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            flush_cnt_q <= '0;
            slot_dat_q  <= '0;
            mask_q      <= '0;
            empty_q     <= 1'b0;
        end else begin
            dec_data_q  <= dec_data_d;
            len_q       <= len_d;
            err_q       <= err_d;
            flush_cnt_q <= flush_cnt_d;
            slot_dat_q  <= slot_dat_d;
            mask_q      <= mask_d;
            empty_q     <= empty_d;
        end
    end

    always_comb begin
        s_ready_out   = reset_in && ((state_q == ST_IDLE) || (state_q == ST_STREAM));
        dec_reset_out = (state_q == ST_IDLE);
        dec_data_out  = dec_data_q;
        empty_out     = empty_q;
        m_valid_out   = drain_vld;
        m_data_out    = '0;
        m_slot_out    = '0;
        m_last_out    = 1'b0;
        m_err_out     = 1'b0;
        if (drain_vld) begin
            m_data_out = slot_dat_q[pick_idx*DATA_W +: DATA_W];
            m_slot_out = pick_idx;
            m_last_out = pick_last;
            m_err_out  = err_q;
        end
    end

endmodule

// File: tb/tb_uniq_frame_ctrl.sv
// Directed bench for uniq_frame_ctrl with a behavioural unique-value decoder attached.
// Expected output beats are queued from each frame's contents and popped as the DUT drains.
module tb_uniq_frame_ctrl;

    localparam int DATA_W    = 8;
    localparam int NUM_SLOTS = 4;
    localparam int MAX_LEN   = 16;
    localparam int FLUSH_CYC = 2;

    logic                        clk_in;
    logic                        reset_in;
    logic [DATA_W-1:0]           s_data_in;
    logic                        s_valid_in;
    logic                        s_last_in;
    logic                        s_ready_out;
    logic                        dec_reset_out;
    logic [DATA_W-1:0]           dec_data_out;
    logic [NUM_SLOTS*DATA_W-1:0] dec_out_in;
    logic [NUM_SLOTS-1:0]        dec_valid_in;
    logic [DATA_W-1:0]           m_data_out;
    logic [1:0]                  m_slot_out;
    logic                        m_valid_out;
    logic                        m_last_out;
    logic                        m_err_out;
    logic                        m_ready_in;
    logic                        empty_out;

    typedef struct {
        logic [7:0] dat;
        logic [1:0] slot;
        logic       last;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] frame_q[$];
    int         vectors;
    int         miscompares;

    logic [3:0][7:0] mdl_val;
    logic [3:0]      mdl_vld;
    logic            force_empty;

    uniq_frame_ctrl #(
        .DATA_W    (DATA_W),
        .NUM_SLOTS (NUM_SLOTS),
        .MAX_LEN   (MAX_LEN),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .s_data_in     (s_data_in),
        .s_valid_in    (s_valid_in),
        .s_last_in     (s_last_in),
        .s_ready_out   (s_ready_out),
        .dec_reset_out (dec_reset_out),
        .dec_data_out  (dec_data_out),
        .dec_out_in    (dec_out_in),
        .dec_valid_in  (dec_valid_in),
        .m_data_out    (m_data_out),
        .m_slot_out    (m_slot_out),
        .m_valid_out   (m_valid_out),
        .m_last_out    (m_last_out),
        .m_err_out     (m_err_out),
        .m_ready_in    (m_ready_in),
        .empty_out     (empty_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Decoder model: one-cycle latency, stores each first-seen symbol into the next free slot.
    always @(posedge clk_in) begin : dec_model
        bit seen;
        int nxt;
        if (dec_reset_out !== 1'b0) begin
            mdl_vld <= '0;
        end else begin
            seen = 1'b0;
            nxt  = 4;
            for (int k = 3; k >= 0; k--) begin
                if (mdl_vld[k] && (mdl_val[k] == dec_data_out)) seen = 1'b1;
                if (!mdl_vld[k]) nxt = k;
            end
            if (!seen && nxt < 4) begin
                mdl_val[nxt] <= dec_data_out;
                mdl_vld[nxt] <= 1'b1;
            end
        end
    end

    assign dec_out_in   = mdl_val;
    assign dec_valid_in = force_empty ? 4'b0000 : mdl_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_expected();
        logic [7:0] u[$];
        int         n;
        bit         dup;
        exp_t       e;
        n = (frame_q.size() > MAX_LEN) ? MAX_LEN : frame_q.size();
        for (int i = 0; i < n; i++) begin
            dup = 1'b0;
            foreach (u[j]) if (u[j] == frame_q[i]) dup = 1'b1;
            if (!dup && u.size() < NUM_SLOTS) u.push_back(frame_q[i]);
        end
        for (int i = 0; i < u.size(); i++) begin
            e.dat  = u[i];
            e.slot = 2'(i);
            e.last = (i == u.size() - 1);
            e.err  = (frame_q.size() > MAX_LEN);
            exp_q.push_back(e);
        end
    endtask

    // Sends frame_q, checks flush/capture timing, then drains with a repeating ready pattern.
    task automatic run_frame(input logic [7:0] pat, input int plen, input int abort_after);
        bit   acc;
        int   w;
        int   ph;
        int   hs;
        int   n_exp;
        bit   done;
        exp_t e;

        for (int i = 0; i < frame_q.size(); i++) begin
            s_valid_in = 1'b1;
            s_data_in  = frame_q[i];
            s_last_in  = (i == frame_q.size() - 1);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 50) begin
                acc = s_ready_out;
                tick();
                w++;
            end
            if (!acc) begin
                chk("s_ready timeout", 32'(acc), 32'd1);
                s_valid_in = 1'b0;
                return;
            end
            if (i == 0) chk("dec_reset low in frame", 32'(dec_reset_out), 32'd0);
        end
        s_valid_in = 1'b0;
        s_last_in  = 1'b0;

        for (int k = 0; k <= FLUSH_CYC; k++) begin
            chk("no m_valid during flush", 32'(m_valid_out), 32'd0);
            chk("s_ready low during flush", 32'(s_ready_out), 32'd0);
            tick();
        end

        n_exp = exp_q.size();
        if (n_exp == 0) begin
            chk("empty pulse", 32'(empty_out), 32'd1);
            chk("empty no m_valid", 32'(m_valid_out), 32'd0);
            chk("empty back to idle", 32'(s_ready_out), 32'd1);
            tick();
            chk("empty pulse ends", 32'(empty_out), 32'd0);
            chk("empty still no m_valid", 32'(m_valid_out), 32'd0);
            return;
        end

        chk("first beat latency", 32'(m_valid_out), 32'd1);
        ph   = 0;
        hs   = 0;
        w    = 0;
        done = 1'b0;
        while (!done && w < 200 && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("m_valid held", 32'(m_valid_out), 32'd1);
            chk("m_data", 32'(m_data_out), 32'(e.dat));
            chk("m_slot", 32'(m_slot_out), 32'(e.slot));
            chk("m_last", 32'(m_last_out), 32'(e.last));
            chk("m_err", 32'(m_err_out), 32'(e.err));
            if (abort_after > 0 && hs == abort_after) begin
                m_ready_in = 1'b0;
                reset_in   = 1'b0;
                tick();
                chk("abort m_valid", 32'(m_valid_out), 32'd0);
                chk("abort dec_reset", 32'(dec_reset_out), 32'd1);
                chk("abort s_ready", 32'(s_ready_out), 32'd0);
                chk("abort m_data", 32'(m_data_out), 32'd0);
                chk("abort dec_data", 32'(dec_data_out), 32'd0);
                reset_in = 1'b1;
                exp_q.delete();
                tick();
                chk("abort recovered idle", 32'(s_ready_out), 32'd1);
                return;
            end
            m_ready_in = pat[ph % plen];
            ph++;
            if (m_ready_in) begin
                hs++;
                void'(exp_q.pop_front());
                if (e.last) done = 1'b1;
            end
            tick();
            w++;
        end
        m_ready_in = 1'b0;
        chk("handshake count", 32'(hs), 32'(n_exp));
        chk("drain done m_valid", 32'(m_valid_out), 32'd0);
        chk("dec_reset after drain", 32'(dec_reset_out), 32'd1);
        chk("s_ready after drain", 32'(s_ready_out), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_in    = 1'b0;
        s_data_in   = '0;
        s_valid_in  = 1'b0;
        s_last_in   = 1'b0;
        m_ready_in  = 1'b0;
        force_empty = 1'b0;

        repeat (3) tick();
        chk("rst s_ready", 32'(s_ready_out), 32'd0);
        chk("rst dec_reset", 32'(dec_reset_out), 32'd1);
        chk("rst dec_data", 32'(dec_data_out), 32'd0);
        chk("rst m_valid", 32'(m_valid_out), 32'd0);
        chk("rst m_last", 32'(m_last_out), 32'd0);
        chk("rst m_err", 32'(m_err_out), 32'd0);
        chk("rst m_data", 32'(m_data_out), 32'd0);
        chk("rst m_slot", 32'(m_slot_out), 32'd0);
        chk("rst empty", 32'(empty_out), 32'd0);
        reset_in = 1'b1;
        tick();
        chk("idle s_ready", 32'(s_ready_out), 32'd1);
        chk("idle dec_reset", 32'(dec_reset_out), 32'd1);

        frame_q = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h01};
        push_expected();
        run_frame(8'hFF, 1, 0);

        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04};
        push_expected();
        run_frame(8'hFF, 1, 0);

        push_expected();
        run_frame(8'b0000_1001, 4, 0);

        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back((i % 2 == 1) ? 8'h11 : 8'h10);
        frame_q.push_back(8'h20);
        frame_q.push_back(8'h21);
        frame_q.push_back(8'h22);
        frame_q.push_back(8'h23);
        push_expected();
        run_frame(8'hFF, 1, 0);

        force_empty = 1'b1;
        frame_q = '{8'h05, 8'h06};
        run_frame(8'hFF, 1, 0);
        force_empty = 1'b0;

        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04};
        push_expected();
        run_frame(8'hFF, 1, 1);

        frame_q = '{8'h07, 8'h08, 8'h07, 8'h09};
        push_expected();
        run_frame(8'hFF, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
